// File: rtl/kb_event_sequencer_pkg.sv
// Shared constants and types for the PS/2 set-2 event sequencer.
package kb_event_sequencer_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;

    localparam logic [7:0] FLT_00 = 8'h00;
    localparam logic [7:0] FLT_FF = 8'hFF;
    localparam logic [7:0] FLT_AA = 8'hAA;
    localparam logic [7:0] FLT_FA = 8'hFA;
    localparam logic [7:0] FLT_FE = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kb_state_t;

    // Event word {ext, brk, code[7:0]}
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kb_evt_t;

    localparam int EVT_W = $bits(kb_evt_t);

    // Bytes that are keyboard housekeeping, not key data
    function automatic logic is_filtered(input logic [7:0] b);
        return (b == FLT_00) || (b == FLT_FF) || (b == FLT_AA) ||
               (b == FLT_FA) || (b == FLT_FE);
    endfunction

endpackage

// File: rtl/kb_evt_fifo.sv
// Show-ahead event FIFO: head word is visible on dout whenever not empty.
import kb_event_sequencer_pkg::*;

module kb_evt_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  kb_evt_t                  din,
    input  logic                     pop,
    output kb_evt_t                  dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    kb_evt_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            pop_ok;
    logic            push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;

    assign count_next = count + CW'(push_ok) - CW'(pop_ok);

    // Empty FIFO presents an all-zero word so outputs match reset values
    assign dout = empty ? '0 : mem[rd_ptr];

    // Storage array, no reset needed: reads are masked while empty
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

endmodule

// File: rtl/kb_event_sequencer.sv
// PS/2 receive sequencer: parses E0/F0 prefixes into key events and queues them.
import kb_event_sequencer_pkg::*;

module kb_event_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_done_tick,
    input  logic [7:0]                    rx_data,
    output logic                          rx_en,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_brk,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    output logic                          timeout
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    kb_state_t       state_q, state_d;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic            push;
    kb_evt_t         push_evt;
    kb_evt_t         head;
    logic            empty;
    logic [CW-1:0]   count_next;
    logic            drop;

    // Parser next-state: a received byte always takes priority over timeout
    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_evt = '0;
        tmo_hit  = 1'b0;
        if (rx_done_tick) begin
            if (is_filtered(rx_data)) begin
                state_d = ST_IDLE;
            end else if (rx_data == PS2_E0) begin
                state_d = ST_EXT;
            end else if (rx_data == PS2_F0) begin
                state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
            end else begin
                push          = 1'b1;
                push_evt.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                push_evt.brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
                push_evt.code = rx_data;
                state_d       = ST_IDLE;
            end
        end else if (state_q != ST_IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_hit = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // Parser state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Prefix timeout counter: runs only while waiting inside a prefix sequence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                        tmo_cnt <= '0;
        else if (rx_done_tick || state_q == ST_IDLE || tmo_hit) tmo_cnt <= '0;
        else                                               tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Status flags: timeout pulse, sticky overflow, receiver gate from next occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout  <= 1'b0;
            overflow <= 1'b0;
            rx_en    <= 1'b1;
        end else begin
            timeout  <= tmo_hit;
            if (drop) overflow <= 1'b1;
            rx_en    <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    kb_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .din        (push_evt),
        .pop        (evt_valid & evt_ready),
        .dout       (head),
        .empty      (empty),
        .count      (evt_count),
        .count_next (count_next),
        .drop       (drop)
    );

    assign evt_valid = ~empty;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_brk   = head.brk;

endmodule

// File: tb/tb_kb_event_sequencer.sv
// Directed bench for kb_event_sequencer (FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_kb_event_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic [2:0] evt_count;
    logic       overflow;
    logic       timeout;

    int vec = 0;
    int errs = 0;

    kb_event_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_brk      (evt_brk),
        .evt_count    (evt_count),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // {valid, ext, brk, code} snapshot of the FIFO head
    function automatic logic [10:0] head();
        return {evt_valid, evt_ext, evt_brk, evt_code};
    endfunction

    // All tasks start and end at a falling edge; inputs change there
    task automatic send(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_data      = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic pop1();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (head() !== 11'h000) begin errs++; $display("FAIL reset_head: got %h want %h", head(), 11'h000); end
        vec++; if (evt_count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", evt_count); end
        vec++; if ({rx_en, overflow, timeout} !== 3'b100) begin errs++; $display("FAIL reset_flags: got %b want 100", {rx_en, overflow, timeout}); end
    endtask

    task automatic test_make();
        evt_ready = 1'b1;
        send(8'h1C);
        vec++; if (head() !== {3'b100, 8'h1C}) begin errs++; $display("FAIL make_1c: got %h want %h", head(), {3'b100, 8'h1C}); end
        @(negedge clk);
        evt_ready = 1'b0;
        vec++; if ({evt_valid, evt_count} !== 4'b0000) begin errs++; $display("FAIL make_popped: got %b want 0000", {evt_valid, evt_count}); end
    endtask

    task automatic test_prefix();
        send(8'hF0);
        vec++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL prefix_f0_noevt: got %b want 0", evt_valid); end
        send(8'h1C);
        vec++; if (head() !== {3'b101, 8'h1C}) begin errs++; $display("FAIL prefix_brk_1c: got %h want %h", head(), {3'b101, 8'h1C}); end
        pop1();
        send(8'hE0);
        send(8'hF0);
        vec++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL prefix_e0f0_noevt: got %b want 0", evt_valid); end
        send(8'h75);
        vec++; if (head() !== {3'b111, 8'h75}) begin errs++; $display("FAIL prefix_extbrk_75: got %h want %h", head(), {3'b111, 8'h75}); end
        pop1();
        send(8'hE0);
        send(8'h6B);
        vec++; if (head() !== {3'b110, 8'h6B}) begin errs++; $display("FAIL prefix_ext_6b: got %h want %h", head(), {3'b110, 8'h6B}); end
        pop1();
        // F0 then E0 restarts as an extended make
        send(8'hF0);
        send(8'hE0);
        send(8'h74);
        vec++; if (head() !== {3'b110, 8'h74}) begin errs++; $display("FAIL prefix_restart_74: got %h want %h", head(), {3'b110, 8'h74}); end
        pop1();
    endtask

    task automatic test_filter();
        logic [7:0] flt [5] = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
        for (int i = 0; i < 5; i++) begin
            send(flt[i]);
            send(8'hF0);
            send(flt[i]);
        end
        vec++; if ({evt_valid, evt_count} !== 4'b0000) begin errs++; $display("FAIL filter_noevt: got %b want 0000", {evt_valid, evt_count}); end
        send(8'h1C);
        vec++; if (head() !== {3'b100, 8'h1C}) begin errs++; $display("FAIL filter_idle_1c: got %h want %h", head(), {3'b100, 8'h1C}); end
        pop1();
        send(8'hE0);
        send(8'hAA);
        send(8'h1C);
        vec++; if (head() !== {3'b100, 8'h1C}) begin errs++; $display("FAIL filter_e0_aa_1c: got %h want %h", head(), {3'b100, 8'h1C}); end
        pop1();
    endtask

    task automatic test_timeout();
        int first = 0;
        int pulses = 0;
        send(8'hE0);
        for (int i = 1; i <= TMO + 6; i++) begin
            @(negedge clk);
            if (timeout) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        vec++; if (first !== TMO) begin errs++; $display("FAIL timeout_latency: got %0d want %0d", first, TMO); end
        vec++; if (pulses !== 1) begin errs++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
        vec++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL timeout_noevt: got %b want 0", evt_valid); end
        send(8'h1C);
        vec++; if (head() !== {3'b100, 8'h1C}) begin errs++; $display("FAIL timeout_then_1c: got %h want %h", head(), {3'b100, 8'h1C}); end
        pop1();
        // Byte arriving on the expiry cycle is parsed, no timeout
        pulses = 0;
        send(8'hE0);
        repeat (TMO - 1) @(negedge clk);
        send(8'h1C);
        if (timeout) pulses++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (timeout) pulses++;
        end
        vec++; if (pulses !== 0) begin errs++; $display("FAIL timeout_tick_wins_pulse: got %0d want 0", pulses); end
        vec++; if (head() !== {3'b110, 8'h1C}) begin errs++; $display("FAIL timeout_tick_wins_evt: got %h want %h", head(), {3'b110, 8'h1C}); end
        pop1();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
        do_reset();
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        vec++; if ({evt_count, rx_en} !== {3'd4, 1'b0}) begin errs++; $display("FAIL b2b_full: got %b want 1000", {evt_count, rx_en}); end
        evt_ready    = 1'b1;
        rx_done_tick = 1'b1;
        rx_data      = 8'hB5;
        @(negedge clk);
        evt_ready    = 1'b0;
        rx_done_tick = 1'b0;
        vec++; if ({evt_count, overflow} !== {3'd4, 1'b0}) begin errs++; $display("FAIL b2b_count_ovf: got %b want 1000", {evt_count, overflow}); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (head() !== {3'b100, exp[i]}) begin errs++; $display("FAIL b2b_drain%0d: got %h want %h", i, head(), {3'b100, exp[i]}); end
            pop1();
        end
        vec++; if ({evt_valid, rx_en} !== 2'b01) begin errs++; $display("FAIL b2b_empty: got %b want 01", {evt_valid, rx_en}); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send(exp[i]);
        vec++; if ({evt_count, rx_en, overflow} !== {3'd4, 2'b00}) begin errs++; $display("FAIL ovf_full: got %b want 10000", {evt_count, rx_en, overflow}); end
        send(8'h55);
        vec++; if ({evt_count, overflow} !== {3'd4, 1'b1}) begin errs++; $display("FAIL ovf_drop: got %b want 1001", {evt_count, overflow}); end
        // Head must hold while not accepted
        repeat (3) @(negedge clk);
        vec++; if (head() !== {3'b100, 8'h11}) begin errs++; $display("FAIL ovf_hold: got %h want %h", head(), {3'b100, 8'h11}); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (head() !== {3'b100, exp[i]}) begin errs++; $display("FAIL ovf_drain%0d: got %h want %h", i, head(), {3'b100, exp[i]}); end
            pop1();
        end
        vec++; if ({evt_valid, evt_count, rx_en, overflow} !== 6'b0_000_11) begin errs++; $display("FAIL ovf_after: got %b want 000011", {evt_valid, evt_count, rx_en, overflow}); end
    endtask

    task automatic test_reset_mid();
        send(8'h12);
        send(8'h34);
        send(8'hE0);
        send(8'hF0);
        reset = 1'b0;
        #1;
        vec++; if ({head(), evt_count} !== 14'h0) begin errs++; $display("FAIL rstmid_outputs: got %h want 0", {head(), evt_count}); end
        vec++; if ({rx_en, overflow, timeout} !== 3'b100) begin errs++; $display("FAIL rstmid_flags: got %b want 100", {rx_en, overflow, timeout}); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(8'h1C);
        vec++; if ({head(), evt_count} !== {3'b100, 8'h1C, 3'd1}) begin errs++; $display("FAIL rstmid_1c: got %h want %h", {head(), evt_count}, {3'b100, 8'h1C, 3'd1}); end
        pop1();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_make();
        test_prefix();
        test_filter();
        test_timeout();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
